// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: datapath widths, opcodes and the memory-stage state encoding.
package lc2k_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_IDX_W = 3;
  localparam int unsigned OPC_W     = 3;

  localparam logic [OPC_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OPC_W-1:0] OP_NOR  = 3'b001;
  localparam logic [OPC_W-1:0] OP_LW   = 3'b010;
  localparam logic [OPC_W-1:0] OP_SW   = 3'b011;
  localparam logic [OPC_W-1:0] OP_BEQ  = 3'b100;
  localparam logic [OPC_W-1:0] OP_JALR = 3'b101;
  localparam logic [OPC_W-1:0] OP_HALT = 3'b110;
  localparam logic [OPC_W-1:0] OP_NOOP = 3'b111;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_READ = 2'd1,
    MS_FULL = 2'd2
  } ms_state_t;

endpackage

// File: rtl/dmem_sync_ram.sv
// Single-clock data RAM with one read and one write port, write-first on address collision.
// Storage is 2-state so every word reads as zero until first written; reset does not touch it.
module dmem_sync_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  bit [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// LC2K memory stage: performs lw/sw on the local data RAM, forwards ALU results,
// and holds one write-back token under valid/ready backpressure.
module mem_stage_ctrl
  import lc2k_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH),
  parameter int unsigned DEST_W = REG_IDX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic              ex_reg_write,
  input  logic [DATA_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic [DEST_W-1:0] ex_dest,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [DEST_W-1:0] wb_dest,
  output logic              wb_reg_write,
  output logic              addr_err
);

  ms_state_t         state;
  ms_state_t         state_nxt;
  logic              accept;
  logic              is_load;
  logic              is_store;
  logic              in_range;
  logic              ram_we;
  logic              ram_re;
  logic              rd_oob;
  logic [DATA_W-1:0] ram_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = is_load ? MS_READ : MS_FULL;
    end else if (state == MS_READ) begin
      state_nxt = MS_FULL;
    end else if ((state == MS_FULL) && wb_ready) begin
      state_nxt = MS_IDLE;
    end
  end

  // Handshake and RAM strobes; a simultaneous load+store is handled as a load
  always_comb begin
    ex_ready = 1'b0;
    accept   = 1'b0;
    is_load  = ex_is_load;
    is_store = ex_is_store & ~ex_is_load;
    in_range = ex_addr < DATA_W'(DEPTH);
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    wb_valid = (state == MS_FULL);
    ex_ready = (state == MS_IDLE) || ((state == MS_FULL) && wb_ready);
    accept   = ex_valid & ex_ready;
    ram_we   = accept & is_store & in_range & ~reset;
    ram_re   = accept & is_load;
  end

  // Token register, out-of-range tracking and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data      <= '0;
      wb_dest      <= '0;
      wb_reg_write <= 1'b0;
      addr_err     <= 1'b0;
      rd_oob       <= 1'b0;
    end else begin
      if (accept) begin
        wb_dest <= ex_dest;
        if (is_load) begin
          rd_oob       <= ~in_range;
          wb_reg_write <= ex_reg_write;
        end else if (is_store) begin
          wb_data      <= ex_wdata;
          wb_reg_write <= 1'b0;
        end else begin
          wb_data      <= ex_addr;
          wb_reg_write <= ex_reg_write;
        end
        if (((is_load || is_store) && !in_range) || (ex_is_load && ex_is_store)) begin
          addr_err <= 1'b1;
        end
      end else if (state == MS_READ) begin
        wb_data <= rd_oob ? '0 : ram_rdata;
      end
    end
  end

  dmem_sync_ram #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_dmem (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ex_addr[ADDR_W-1:0]),
    .wdata(ex_wdata),
    .re   (ram_re),
    .raddr(ex_addr[ADDR_W-1:0]),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed scenarios plus random traffic against a
// transaction-level model (word array, token queue with due cycles, sticky error).
module tb_mem_stage_ctrl;

  logic        clk;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_load;
  logic        ex_is_store;
  logic        ex_reg_write;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [2:0]  ex_dest;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [2:0]  wb_dest;
  logic        wb_reg_write;
  logic        addr_err;

  mem_stage_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_is_load  (ex_is_load),
    .ex_is_store (ex_is_store),
    .ex_reg_write(ex_reg_write),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .ex_dest     (ex_dest),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_data     (wb_data),
    .wb_dest     (wb_dest),
    .wb_reg_write(wb_reg_write),
    .addr_err    (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  dest;
    logic        rw;
    int          due;
  } tok_t;

  tok_t        q[$];
  logic [31:0] mem_m [64];
  logic        err_m;
  int          cyc;
  int          n_checks;
  int          n_fail;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock of traffic: check outputs, drive inputs, advance the model, clock.
  task automatic step(input logic v, input logic ld, input logic st, input logic rw,
                      input logic [31:0] a, input logic [31:0] wd, input logic [2:0] d,
                      input logic wbr, input logic rst);
    logic exp_valid;
    tok_t t;
    @(negedge clk);
    exp_valid = (q.size() > 0) && (cyc >= q[0].due);
    check("wb_valid", 32'(wb_valid), 32'(exp_valid));
    if (exp_valid && wb_valid) begin
      check("wb_data", wb_data, q[0].data);
      check("wb_reg_write", 32'(wb_reg_write), 32'(q[0].rw));
      if (q[0].rw) check("wb_dest", 32'(wb_dest), 32'(q[0].dest));
    end
    check("addr_err", 32'(addr_err), 32'(err_m));
    reset        = rst;
    ex_valid     = v;
    ex_is_load   = ld;
    ex_is_store  = st;
    ex_reg_write = rw;
    ex_addr      = a;
    ex_wdata     = wd;
    ex_dest      = d;
    wb_ready     = wbr;
    #1;
    if (rst) begin
      q.delete();
      err_m = 1'b0;
    end else begin
      check("ex_ready", 32'(ex_ready),
            32'((q.size() == 0) || ((cyc >= q[0].due) && wbr)));
      if (exp_valid && wbr) void'(q.pop_front());
      if (v && ex_ready) begin
        if (((ld || st) && (a >= 32'd64)) || (ld && st)) err_m = 1'b1;
        t.dest = d;
        if (ld) begin
          t.data = (a < 32'd64) ? mem_m[a[5:0]] : 32'd0;
          t.rw   = rw;
          t.due  = cyc + 2;
        end else if (st) begin
          if (a < 32'd64) mem_m[a[5:0]] = wd;
          t.data = wd;
          t.rw   = 1'b0;
          t.due  = cyc + 1;
        end else begin
          t.data = a;
          t.rw   = rw;
          t.due  = cyc + 1;
        end
        q.push_back(t);
      end
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    logic [31:0] a;
    logic        ld;
    logic        st;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    err_m    = 1'b0;
    foreach (mem_m[i]) mem_m[i] = 32'd0;
    reset = 1'b1; ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_reg_write = 0;
    ex_addr = 0; ex_wdata = 0; ex_dest = 0; wb_ready = 0;
    repeat (3) @(posedge clk);

    // Reset state
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_wb_dest", 32'(wb_dest), 32'd0);
    check("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_addr_err", 32'(addr_err), 32'd0);
    @(posedge clk);
    idle(2);

    // Store then load to the same word on consecutive accepts
    step(1, 0, 1, 0, 32'd7, 32'd5, 3'd0, 1, 0);
    step(1, 1, 0, 1, 32'd7, 32'd0, 3'd2, 1, 0);
    idle(3);

    // Three back-to-back ALU results
    step(1, 0, 0, 1, 32'h11, 32'd0, 3'd1, 1, 0);
    step(1, 0, 0, 1, 32'h22, 32'd0, 3'd3, 1, 0);
    step(1, 0, 0, 1, 32'h33, 32'd0, 3'd4, 1, 0);
    idle(2);

    // Backpressure: token held for 4 cycles, then released with a new accept
    step(1, 0, 0, 1, 32'h44, 32'd0, 3'd5, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 32'h55, 32'd0, 3'd6, 0, 0);
    step(1, 0, 0, 1, 32'h55, 32'd0, 3'd6, 1, 0);
    idle(2);

    // Out-of-range store and load, then confirm word 0 untouched
    step(1, 0, 1, 0, 32'd64, 32'd9, 3'd0, 1, 0);
    step(1, 1, 0, 1, 32'd64, 32'd0, 3'd1, 1, 0);
    idle(3);
    step(1, 1, 0, 1, 32'd0, 32'd0, 3'd2, 1, 0);
    idle(3);

    // Load and store asserted together behave as a load
    step(1, 1, 1, 1, 32'd7, 32'hBAD, 3'd3, 1, 0);
    idle(3);

    // Reset during READ, with a store presented on the reset edge
    step(1, 0, 1, 0, 32'd3, 32'hCAFE, 3'd0, 1, 0);
    step(1, 1, 0, 1, 32'd3, 32'd0, 3'd4, 1, 0);
    step(1, 0, 1, 0, 32'd3, 32'hDEAD, 3'd0, 1, 1);
    idle(1);
    step(1, 1, 0, 1, 32'd3, 32'd0, 3'd5, 1, 0);
    idle(3);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(9))
        0, 1, 2, 3, 4, 5, 6: a = 32'($urandom_range(15));
        7, 8:                a = 32'($urandom_range(63));
        default:             a = ($urandom_range(1) != 0) ? 32'(64 + $urandom_range(8)) : $urandom;
      endcase
      ld = ($urandom_range(2) == 0);
      st = !ld && ($urandom_range(2) == 0);
      if ($urandom_range(49) == 0) begin
        ld = 1'b1;
        st = 1'b1;
      end
      step($urandom_range(3) != 0, ld, st, $urandom_range(1) != 0, a, $urandom,
           3'($urandom_range(7)), $urandom_range(3) != 0, $urandom_range(199) == 0);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
